// File: rtl/tlb_entry_alloc.sv
// tlb_entry_alloc
//   Allocation controller for the TLB entry array. Tracks a valid bit per
//   entry and serialises three operations: invalidate (highest priority),
//   indexed E-bit write, and fill (lowest priority). A fill picks the
//   lowest-numbered invalid entry. When every entry is valid, it picks a
//   round-robin victim.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   fill_valid/ready      fill request handshake
//   wr_valid/ready        indexed write handshake; wr_idx, wr_e payload
//   inv_valid/ready       invalidate handshake; inv_all, inv_mask payload
//   alloc_valid           one-cycle pulse carrying alloc_idx / alloc_evict
//   entry_valid           registered valid vector
//   busy                  high while a fill is in flight (PICK or COMMIT)
module tlb_entry_alloc #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic               wr_e,
  input  logic               inv_valid,
  output logic               inv_ready,
  input  logic               inv_all,
  input  logic [ENTRIES-1:0] inv_mask,
  output logic               alloc_valid,
  output logic [IDXW-1:0]    alloc_idx,
  output logic               alloc_evict,
  output logic [ENTRIES-1:0] entry_valid,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, PICK, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [ENTRIES-1:0]  entry_valid_q, entry_valid_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                alloc_valid_q, alloc_valid_d;
  logic [IDXW-1:0]     alloc_idx_q, alloc_idx_d;
  logic                alloc_evict_q, alloc_evict_d;

  logic                free_found;
  logic [IDXW-1:0]     free_idx;

  // Lowest-numbered invalid entry. The loop runs from the top down, so the
  // last match written is the lowest index.
  always_comb begin
    free_found = ~&entry_valid_q;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid_q[i]) begin
        free_idx = IDXW'(i);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      entry_valid_q <= '0;
      rr_ptr_q      <= '0;
      alloc_valid_q <= 1'b0;
      alloc_idx_q   <= '0;
      alloc_evict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_valid_q <= entry_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_idx_q   <= alloc_idx_d;
      alloc_evict_q <= alloc_evict_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    entry_valid_d = entry_valid_q;
    rr_ptr_d      = rr_ptr_q;
    alloc_valid_d = 1'b0;
    alloc_idx_d   = alloc_idx_q;
    alloc_evict_d = alloc_evict_q;
    case (state_q)
      IDLE: begin
        // In IDLE the readies reduce to this priority chain.
        if (inv_valid) begin
          entry_valid_d = entry_valid_q & ~(inv_all ? {ENTRIES{1'b1}} : inv_mask);
        end else if (wr_valid) begin
          entry_valid_d[wr_idx] = wr_e;
        end else if (fill_valid) begin
          state_d = PICK;
        end
      end
      PICK: begin
        alloc_valid_d = 1'b1;
        state_d       = COMMIT;
        if (free_found) begin
          alloc_idx_d   = free_idx;
          alloc_evict_d = 1'b0;
        end else begin
          // The pointer moves only when an eviction actually consumes it.
          alloc_idx_d   = rr_ptr_q;
          alloc_evict_d = 1'b1;
          rr_ptr_d      = (rr_ptr_q == IDXW'(ENTRIES - 1)) ? '0 : rr_ptr_q + 1'b1;
        end
      end
      COMMIT: begin
        entry_valid_d[alloc_idx_q] = 1'b1;
        state_d                    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    inv_ready  = (state_q == IDLE);
    wr_ready   = (state_q == IDLE) && !inv_valid;
    fill_ready = (state_q == IDLE) && !inv_valid && !wr_valid;
    busy       = (state_q != IDLE);
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_idx   = alloc_idx_q;
  assign alloc_evict = alloc_evict_q;
  assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_tlb_entry_alloc.sv
// Testbench for tlb_entry_alloc. It runs a 16-entry and a 32-entry instance
// in lockstep on shared stimulus. Each instance is compared against an
// array/pointer model of the allocation rules.
module tb_tlb_entry_alloc;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fill_valid, wr_valid, wr_e, inv_valid, inv_all;
  logic [4:0]  wr_idx;
  logic [31:0] inv_mask;

  logic        a_fill_ready, a_wr_ready, a_inv_ready, a_alloc_valid, a_alloc_evict, a_busy;
  logic [3:0]  a_alloc_idx;
  logic [15:0] a_entry_valid;
  logic        b_fill_ready, b_wr_ready, b_inv_ready, b_alloc_valid, b_alloc_evict, b_busy;
  logic [4:0]  b_alloc_idx;
  logic [31:0] b_entry_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: valid bits and round-robin pointer per instance.
  logic [31:0] mv [2];
  int          rr [2];
  int          nent [2] = '{16, 32};
  logic [31:0] wmask [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  tlb_entry_alloc #(.ENTRIES(16), .IDXW(4)) dut16 (
    .clk(clk), .resetn(resetn),
    .fill_valid(fill_valid), .fill_ready(a_fill_ready),
    .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_idx(wr_idx[3:0]), .wr_e(wr_e),
    .inv_valid(inv_valid), .inv_ready(a_inv_ready), .inv_all(inv_all), .inv_mask(inv_mask[15:0]),
    .alloc_valid(a_alloc_valid), .alloc_idx(a_alloc_idx), .alloc_evict(a_alloc_evict),
    .entry_valid(a_entry_valid), .busy(a_busy)
  );

  tlb_entry_alloc #(.ENTRIES(32), .IDXW(5)) dut32 (
    .clk(clk), .resetn(resetn),
    .fill_valid(fill_valid), .fill_ready(b_fill_ready),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_idx(wr_idx), .wr_e(wr_e),
    .inv_valid(inv_valid), .inv_ready(b_inv_ready), .inv_all(inv_all), .inv_mask(inv_mask),
    .alloc_valid(b_alloc_valid), .alloc_idx(b_alloc_idx), .alloc_evict(b_alloc_evict),
    .entry_valid(b_entry_valid), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Fill outcome from the allocation rules: the first hole wins; otherwise
  // the pointer victim is chosen and the pointer moves on modulo the size.
  task automatic model_fill(input int k, output int idx, output bit ev);
    idx = -1;
    for (int i = 0; i < nent[k]; i++)
      if (!mv[k][i] && idx < 0) idx = i;
    if (idx < 0) begin
      idx   = rr[k];
      ev    = 1'b1;
      rr[k] = (rr[k] + 1) % nent[k];
    end else begin
      ev = 1'b0;
    end
    mv[k][idx] = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = '0;
      rr[k] = 0;
    end
  endtask

  task automatic check_entries(input string tag);
    check_eq({tag, "_ev16"}, {16'h0, a_entry_valid}, mv[0]);
    check_eq({tag, "_ev32"}, b_entry_valid, mv[1]);
  endtask

  // Tasks start and end at a falling edge. They drive inputs first, then
  // wait #1 before sampling combinational readies.
  task automatic reset_dut();
    resetn = 1'b0;
    fill_valid = 0; wr_valid = 0; inv_valid = 0; inv_all = 0;
    wr_idx = '0; wr_e = 0; inv_mask = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    #1;
    check_entries("reset");
    check_eq("reset_alloc", {a_alloc_valid, a_alloc_evict, 1'b0, a_alloc_idx,
                             b_alloc_valid, b_alloc_evict, b_alloc_idx}, 32'h0);
    check_eq("reset_busy", {a_busy, b_busy}, 2'b00);
    check_eq("reset_rdy", {a_inv_ready, a_wr_ready, a_fill_ready,
                           b_inv_ready, b_wr_ready, b_fill_ready}, 6'b111111);
  endtask

  task automatic do_fill(output int got16, output int got32, output bit ev16, output bit ev32);
    int          ei0, ei1;
    bit          ee0, ee1;
    logic [31:0] pre0, pre1;
    pre0 = mv[0];
    pre1 = mv[1];
    model_fill(0, ei0, ee0);
    model_fill(1, ei1, ee1);
    fill_valid = 1'b1;
    #1;
    check_eq("fill_ready", {a_fill_ready, b_fill_ready}, 2'b11);
    check_eq("fill_idle_busy", {a_busy, b_busy}, 2'b00);
    @(negedge clk);                       // PICK
    fill_valid = 1'b0;
    #1;
    check_eq("pick_busy", {a_busy, b_busy}, 2'b11);
    check_eq("pick_no_pulse", {a_alloc_valid, b_alloc_valid}, 2'b00);
    check_eq("pick_rdy", {a_inv_ready, a_fill_ready, b_inv_ready, b_fill_ready}, 4'b0000);
    @(negedge clk);                       // COMMIT
    check_eq("commit_pulse", {a_alloc_valid, b_alloc_valid}, 2'b11);
    check_eq("alloc_idx16", {28'h0, a_alloc_idx}, ei0);
    check_eq("alloc_idx32", {27'h0, b_alloc_idx}, ei1);
    check_eq("alloc_evict", {a_alloc_evict, b_alloc_evict}, {ee0, ee1});
    check_eq("commit_ev16", {16'h0, a_entry_valid}, pre0);
    check_eq("commit_ev32", b_entry_valid, pre1);
    got16 = int'(a_alloc_idx);
    got32 = int'(b_alloc_idx);
    ev16  = a_alloc_evict;
    ev32  = b_alloc_evict;
    @(negedge clk);                       // back in IDLE
    check_eq("post_pulse", {a_alloc_valid, b_alloc_valid}, 2'b00);
    check_eq("post_busy", {a_busy, b_busy}, 2'b00);
    check_entries("fill");
    $display("fill   idx16=%0d ev=%0d idx32=%0d ev=%0d", got16, ev16, got32, ev32);
  endtask

  task automatic do_inv(input bit all, input logic [31:0] mask);
    inv_valid = 1'b1; inv_all = all; inv_mask = mask;
    #1;
    check_eq("inv_ready", {a_inv_ready, b_inv_ready}, 2'b11);
    @(negedge clk);
    inv_valid = 1'b0; inv_all = 1'b0; inv_mask = '0;
    for (int k = 0; k < 2; k++)
      mv[k] = all ? 32'h0 : (mv[k] & ~mask & wmask[k]);
    check_entries("inv");
    $display("inv    all=%0d mask=0x%08h", all, mask);
  endtask

  task automatic do_wr(input logic [4:0] idx, input bit e);
    wr_valid = 1'b1; wr_idx = idx; wr_e = e;
    #1;
    check_eq("wr_ready", {a_wr_ready, b_wr_ready}, 2'b11);
    @(negedge clk);
    wr_valid = 1'b0;
    mv[0][idx % 16] = e;
    mv[1][idx]      = e;
    check_entries("wr");
    $display("wr     idx=%0d e=%0d", idx, e);
  endtask

  initial begin
    int  i16, i32;
    bit  e16, e32;

    reset_dut();

    // Sequential fills from empty, then the rest of the 16-entry array.
    for (int j = 0; j < 16; j++) begin
      do_fill(i16, i32, e16, e32);
      check_eq("seq_idx16", i16, j);
      check_eq("seq_evict16", {31'h0, e16}, 32'h0);
      if (j == 2) check_eq("seq_ev3", {16'h0, a_entry_valid}, 32'h0007);
    end
    check_eq("full_ev16", {16'h0, a_entry_valid}, 32'hFFFF);

    // Full-array eviction: victims 0 then 1.
    for (int j = 0; j < 2; j++) begin
      do_fill(i16, i32, e16, e32);
      check_eq("evict_idx16", i16, j);
      check_eq("evict_flag16", {31'h0, e16}, 32'h1);
    end
    check_eq("evict_ev16", {16'h0, a_entry_valid}, 32'hFFFF);

    // Hole reuse: invalidated holes are preferred; the pointer stays at 2.
    do_inv(1'b0, 32'h0000_0030);
    do_fill(i16, i32, e16, e32);
    check_eq("hole_idx_a", i16, 4);
    check_eq("hole_ev_a", {31'h0, e16}, 32'h0);
    do_fill(i16, i32, e16, e32);
    check_eq("hole_idx_b", i16, 5);
    check_eq("hole_ev_b", {31'h0, e16}, 32'h0);
    do_fill(i16, i32, e16, e32);
    check_eq("hole_rr_idx", i16, 2);
    check_eq("hole_rr_ev", {31'h0, e16}, 32'h1);

    // Simultaneous requests: inv, then wr, then fill.
    inv_valid = 1'b1; inv_all = 1'b1;
    wr_valid = 1'b1; wr_idx = 5'd3; wr_e = 1'b1;
    fill_valid = 1'b1;
    #1;
    check_eq("sim_c0_rdy", {a_inv_ready, a_wr_ready, a_fill_ready,
                            b_inv_ready, b_wr_ready, b_fill_ready}, 6'b100100);
    @(negedge clk);
    inv_valid = 1'b0; inv_all = 1'b0;
    mv[0] = '0; mv[1] = '0;
    #1;
    check_eq("sim_c1_rdy", {a_inv_ready, a_wr_ready, a_fill_ready,
                            b_inv_ready, b_wr_ready, b_fill_ready}, 6'b110110);
    check_eq("sim_c1_ev", {16'h0, a_entry_valid}, 32'h0);
    check_eq("sim_c1_ev32", b_entry_valid, 32'h0);
    @(negedge clk);
    wr_valid = 1'b0;
    mv[0][3] = 1'b1; mv[1][3] = 1'b1;
    #1;
    check_eq("sim_c2_ev", {16'h0, a_entry_valid}, 32'h0008);
    check_eq("sim_c2_ev32", b_entry_valid, 32'h0008);
    do_fill(i16, i32, e16, e32);
    check_eq("sim_fill_idx", i16, 0);
    check_eq("sim_fill_ev", {16'h0, a_entry_valid}, 32'h0009);

    // Reset while a fill is in PICK.
    fill_valid = 1'b1;
    #1;
    check_eq("rst_fill_rdy", {a_fill_ready, b_fill_ready}, 2'b11);
    @(negedge clk);
    fill_valid = 1'b0;
    #1;
    check_eq("rst_pick_busy", {a_busy, b_busy}, 2'b11);
    resetn = 1'b0;
    #1;
    check_eq("rst_async_busy", {a_busy, b_busy}, 2'b00);
    check_eq("rst_async_pulse", {a_alloc_valid, b_alloc_valid}, 2'b00);
    @(negedge clk);
    check_eq("rst_hold_pulse", {a_alloc_valid, b_alloc_valid}, 2'b00);
    resetn = 1'b1;
    model_reset();
    #1;
    check_entries("rst_release");
    check_eq("rst_release_busy", {a_busy, b_busy}, 2'b00);
    @(negedge clk);
    check_eq("rst_no_late_pulse", {a_alloc_valid, b_alloc_valid}, 2'b00);
    do_fill(i16, i32, e16, e32);
    check_eq("rst_fill_idx16", i16, 0);
    check_eq("rst_fill_idx32", i32, 0);

    // Pointer wrap on the 32-entry instance.
    reset_dut();
    for (int j = 0; j < 32; j++) do_fill(i16, i32, e16, e32);
    check_eq("wrap_full32", b_entry_valid, 32'hFFFF_FFFF);
    for (int j = 0; j < 33; j++) begin
      do_fill(i16, i32, e16, e32);
      check_eq("wrap_idx32", i32, j % 32);
      check_eq("wrap_ev32", {31'h0, e32}, 32'h1);
    end

    // Randomized single operations against the model.
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 2)
        do_inv($urandom_range(0, 7) == 0, $urandom() & $urandom());
      else if (op < 4)
        do_wr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        do_fill(i16, i32, e16, e32);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
